// File: rtl/unified_pkt_fifo.sv
// rtl/unified_pkt_fifo.sv - single-clock show-ahead packet FIFO with sideband
//
// Stores {data, sop, eop, empty} per word and presents the oldest entry on
// the output whenever out_valid is high.
//
// Ports:
//   in_clk, in_reset          sole clock, asynchronous active-high reset
//   out_clk, out_reset        unused (single-clock build only)
//   in_data/in_valid/in_ready write side, plus in_startofpacket,
//                             in_endofpacket, in_empty sideband
//   out_data/out_valid/out_ready read side, plus out_startofpacket,
//                             out_endofpacket, out_empty sideband
//   fill_level                occupancy, zero-extended to 32 bits
//   almost_full               occupancy >= FULL_LEVEL (when enabled)
//   overflow                  write attempted while full; word dropped
module unified_pkt_fifo #(
   parameter FIFO_NAME        = "FIFO",
   parameter MEM_TYPE         = "M20K",
   parameter int DUAL_CLOCK       = 0,
   parameter int USE_ALMOST_FULL  = 0,
   parameter int FULL_LEVEL       = 950,
   parameter int SYMBOLS_PER_BEAT = 64,
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int FIFO_DEPTH       = 1024,
   localparam int W  = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
   localparam int EW = $clog2(SYMBOLS_PER_BEAT)
) (
   input  logic          in_clk,
   input  logic          in_reset,
   input  logic          out_clk,
   input  logic          out_reset,
   input  logic [W-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_startofpacket,
   input  logic          in_endofpacket,
   input  logic [EW-1:0] in_empty,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_startofpacket,
   output logic          out_endofpacket,
   output logic [EW-1:0] out_empty,
   output logic [31:0]   fill_level,
   output logic          almost_full,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = W + 2 + EW;

   if (DUAL_CLOCK != 0) begin : g_bad_cfg
      $error("%s: DUAL_CLOCK must be 0, only single-clock operation is supported", FIFO_NAME);
   end

   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_write;
   logic          w_pop;
   logic [DW-1:0] w_head;
   logic          w_unused;

   assign w_unused = out_clk | out_reset;

   assign fill_level = {{(32-AW-1){1'b0}}, r_count};
   // in_ready looks only at the registered count, so a full FIFO never
   // accepts a word in the same cycle as a pop (no write-through).
   assign in_ready   = (fill_level < FIFO_DEPTH);
   assign out_valid  = (r_count != '0);
   assign w_write    = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign overflow   = in_valid & ~in_ready;
   assign almost_full = (USE_ALMOST_FULL != 0) && (fill_level >= FULL_LEVEL);

   assign w_head            = r_mem[r_rd_ptr];
   assign out_data          = w_head[DW-1 -: W];
   assign out_startofpacket = w_head[EW+1];
   assign out_endofpacket   = w_head[EW];
   assign out_empty         = w_head[EW-1:0];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge in_clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= {in_data, in_startofpacket, in_endofpacket, in_empty};
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_write && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_write) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (!in_reset && overflow) begin
         $info("%s (%s): overflow, write dropped while full", FIFO_NAME, MEM_TYPE);
      end
   end

endmodule

// File: tb/tb_unified_pkt_fifo.sv
// tb/tb_unified_pkt_fifo.sv - self-checking bench for unified_pkt_fifo
module tb_unified_pkt_fifo;

   localparam int DEPTH = 8;
   localparam int FULL  = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sop;
   logic       in_eop;
   logic [0:0] in_empty;
   logic       out_ready;

   logic [7:0]  out_data,  n_out_data;
   logic        out_valid, n_out_valid;
   logic        in_ready,  n_in_ready;
   logic        o_sop,     n_sop;
   logic        o_eop,     n_eop;
   logic [0:0]  o_empty,   n_empty;
   logic [31:0] fill,      n_fill;
   logic        af,        n_af;
   logic        ovf,       n_ovf;

   int vectors = 0;
   int miscompares = 0;
   logic [10:0] q[$];

   always #5 clk = ~clk;

   unified_pkt_fifo #(
      .FIFO_NAME("DUT_AF"), .USE_ALMOST_FULL(1), .FULL_LEVEL(FULL),
      .SYMBOLS_PER_BEAT(2), .BITS_PER_SYMBOL(4), .FIFO_DEPTH(DEPTH)
   ) dut (
      .in_clk(clk), .in_reset(rst), .out_clk(1'b0), .out_reset(1'b0),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_startofpacket(o_sop), .out_endofpacket(o_eop), .out_empty(o_empty),
      .fill_level(fill), .almost_full(af), .overflow(ovf)
   );

   unified_pkt_fifo #(
      .FIFO_NAME("DUT_NOAF"), .USE_ALMOST_FULL(0), .FULL_LEVEL(FULL),
      .SYMBOLS_PER_BEAT(2), .BITS_PER_SYMBOL(4), .FIFO_DEPTH(DEPTH)
   ) dut_naf (
      .in_clk(clk), .in_reset(rst), .out_clk(1'b0), .out_reset(1'b0),
      .in_data(in_data), .in_valid(in_valid), .in_ready(n_in_ready),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(out_ready),
      .out_startofpacket(n_sop), .out_endofpacket(n_eop), .out_empty(n_empty),
      .fill_level(n_fill), .almost_full(n_af), .overflow(n_ovf)
   );

   task automatic set_in(input logic v, input logic [7:0] d, input logic s,
                         input logic e, input logic em, input logic r);
      in_valid  = v;
      in_data   = d;
      in_sop    = s;
      in_eop    = e;
      in_empty  = em;
      out_ready = r;
   endtask

   // Reference model: a queue of entries; write accepted when not full,
   // pop when non-empty, both decided from the state before the edge.
   task automatic tick();
      bit wr, pop;
      wr  = in_valid && (q.size() < DEPTH);
      pop = out_ready && (q.size() > 0);
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (wr)  q.push_back({in_data, in_sop, in_eop, in_empty});
      end
      #1;
   endtask

   task automatic drain();
      set_in(0, 8'h00, 0, 0, 0, 1);
      while (q.size() > 0) tick();
      set_in(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(0, 8'h00, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (fill !== 32'd0) begin miscompares++; $display("FAIL reset_fill: got %0d want 0", fill); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full: got %b want 0", af); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", ovf); end
      rst = 1'b0;
      q.delete();
   endtask

   task automatic test_basic_packet();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      set_in(1, 8'h11, 1, 0, 0, 0); tick();
      vectors++; if (fill !== 32'd1) begin miscompares++; $display("FAIL first_write_after_reset: got fill %0d want 1", fill); end
      set_in(1, 8'h22, 0, 0, 0, 0); tick();
      set_in(1, 8'h33, 0, 1, 1, 0); tick();
      set_in(0, 8'h00, 0, 0, 0, 0);
      vectors++; if (fill !== 32'd3) begin miscompares++; $display("FAIL basic_fill: got %0d want 3", fill); end
      vectors++; if (out_data !== 8'h11 || o_sop !== 1'b1) begin miscompares++; $display("FAIL basic_head: got %h sop %b want 11 sop 1", out_data, o_sop); end
      for (int i = 0; i < 3; i++) begin
         vectors++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin miscompares++; $display("FAIL basic_pop_%0d: got %h valid %b want %h", i, out_data, out_valid, exp_d[i]); end
         if (i == 2) begin
            vectors++; if (o_eop !== 1'b1 || o_empty !== 1'b1 || o_sop !== 1'b0) begin miscompares++; $display("FAIL basic_last_sideband: got sop %b eop %b empty %b want 0 1 1", o_sop, o_eop, o_empty); end
         end
         set_in(0, 8'h00, 0, 0, 0, 1); tick();
      end
      set_in(0, 8'h00, 0, 0, 0, 1); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty_after: got valid %b want 0", out_valid); end
      tick();
      vectors++; if (fill !== 32'd0) begin miscompares++; $display("FAIL underflow_pop: got fill %0d want 0", fill); end
      set_in(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic test_full_and_overflow();
      logic [7:0] head;
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0); #1;
         vectors++; if (in_ready !== 1'b1 || ovf !== 1'b0) begin miscompares++; $display("FAIL fill_ready_%0d: got ready %b ovf %b want 1 0", i, in_ready, ovf); end
         tick();
         vectors++; if (af !== (q.size() >= FULL)) begin miscompares++; $display("FAIL almost_full_at_%0d: got %b want %b", q.size(), af, q.size() >= FULL); end
         vectors++; if (n_af !== 1'b0) begin miscompares++; $display("FAIL almost_full_disabled_at_%0d: got %b want 0", q.size(), n_af); end
      end
      vectors++; if (fill !== 32'd8 || in_ready !== 1'b0) begin miscompares++; $display("FAIL full_state: got fill %0d ready %b want 8 0", fill, in_ready); end
      head = q[0][10:3];
      set_in(1, 8'hEE, 0, 0, 0, 0); #1;
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL overflow_pulse: got %b want 1", ovf); end
      tick();
      vectors++; if (fill !== 32'd8 || out_data !== head) begin miscompares++; $display("FAIL overflow_state: got fill %0d head %h want 8 %h", fill, out_data, head); end
      set_in(0, 8'h00, 0, 0, 0, 0); #1;
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL overflow_clear: got %b want 0", ovf); end
   endtask

   task automatic test_full_pop_write();
      logic [7:0] last;
      set_in(1, 8'hA5, 0, 0, 0, 1); tick();
      vectors++; if (fill !== 32'd7) begin miscompares++; $display("FAIL full_pop_only: got fill %0d want 7", fill); end
      set_in(1, 8'h5A, 0, 0, 0, 0); tick();
      vectors++; if (fill !== 32'd8) begin miscompares++; $display("FAIL full_refill: got fill %0d want 8", fill); end
      set_in(0, 8'h00, 0, 0, 0, 1);
      last = 8'h00;
      while (q.size() > 0) begin
         vectors++; if (out_data !== q[0][10:3] || o_sop !== q[0][2] || o_eop !== q[0][1]) begin miscompares++; $display("FAIL full_drain: got %h want %h", out_data, q[0][10:3]); end
         last = out_data;
         tick();
      end
      vectors++; if (last !== 8'h5A) begin miscompares++; $display("FAIL full_drain_tail: got %h want 5a", last); end
      set_in(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin set_in(1, 8'(8'hC0 + i), 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 20; i++) begin
         set_in(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1); #1;
         vectors++; if (out_data !== q[0][10:3] || o_empty !== q[0][0]) begin miscompares++; $display("FAIL b2b_head_%0d: got %h want %h", i, out_data, q[0][10:3]); end
         tick();
         vectors++; if (fill !== 32'd3) begin miscompares++; $display("FAIL b2b_fill_%0d: got %0d want 3", i, fill); end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin set_in(1, 8'(i), 0, 0, 0, 0); tick(); end
      set_in(0, 8'h00, 0, 0, 0, 0);
      vectors++; if (fill !== 32'd5) begin miscompares++; $display("FAIL premid_fill: got %0d want 5", fill); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++; if (fill !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset: got fill %0d valid %b ready %b want 0 0 1", fill, out_valid, in_ready); end
      tick();
      rst = 1'b0;
      set_in(1, 8'h77, 1, 1, 0, 0); tick();
      set_in(0, 8'h00, 0, 0, 0, 0);
      vectors++; if (fill !== 32'd1 || out_data !== 8'h77) begin miscompares++; $display("FAIL post_reset_write: got fill %0d data %h want 1 77", fill, out_data); end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 2) == 0));
         #1;
         vectors++;
         if (fill !== 32'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)
             || af !== (q.size() >= FULL) || n_af !== 1'b0 || ovf !== (in_valid && q.size() == DEPTH)
             || (q.size() != 0 && {out_data, o_sop, o_eop, o_empty} !== q[0])) begin
            miscompares++;
            $display("FAIL random_%0d: got fill %0d head %h af %b ovf %b want fill %0d head %h", i, fill,
                     {out_data, o_sop, o_eop, o_empty}, af, ovf, q.size(), (q.size() != 0) ? q[0] : 11'h0);
         end
         tick();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_full_and_overflow();
      test_full_pop_write();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
